// File: rtl/div_ctrl_fsm.sv
// Sequencing controller for the 10/5-bit restoring divider datapath.
// Runs load, overflow check, N shift/subtract/restore steps, then presents Q and R.
module div_ctrl_fsm #(
  parameter int N     = 5,
  parameter int CNT_W = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  input  logic sign_i,
  input  logic or_d_i,
  input  logic OV_not_i,
  output logic ldd_o,
  output logic ldw_o,
  output logic shw_o,
  output logic ldq_o,
  output logic shq_o,
  output logic q0_o,
  output logic d_sel_o,
  output logic w_sel_o,
  output logic out_sel_o,
  output logic busy_o,
  output logic q_valid_o,
  output logic r_valid_o,
  output logic done_o,
  output logic err_dz_o,
  output logic err_ov_o
);

  typedef enum logic [3:0] {
    IDLE, LOADX, OVCHK, SHIFT, SUB, ADJ, QFIN, OUTQ, OUTR, ERR_DZ, ERR_OV
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               qbit_q, qbit_d;

  logic ldw_q, shw_q, ldq_q, shq_q, q0_q, d_sel_q, w_sel_q, out_sel_q;
  logic busy_q, q_valid_q, r_valid_q, done_q, err_dz_q, err_ov_q;
  logic ldw_d, shw_d, ldq_d, shq_d, q0_d, d_sel_d, w_sel_d, out_sel_d;
  logic busy_d, q_valid_d, r_valid_d, done_d, err_dz_d, err_ov_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    qbit_d  = qbit_q;
    case (state_q)
      IDLE:   if (start_i) state_d = or_d_i ? LOADX : ERR_DZ;
      LOADX: begin
        cnt_d   = '0;
        qbit_d  = 1'b0;
        state_d = OVCHK;
      end
      OVCHK:  state_d = OV_not_i ? SHIFT : ERR_OV;
      SHIFT:  state_d = SUB;
      SUB:    state_d = ADJ;
      ADJ: begin
        qbit_d = ~sign_i;
        if (cnt_q == CNT_W'(N - 1)) begin
          state_d = QFIN;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = SHIFT;
        end
      end
      QFIN:   state_d = OUTQ;
      OUTQ:   state_d = OUTR;
      OUTR, ERR_DZ, ERR_OV: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered copy matches the current state.
  always_comb begin
    ldw_d = 1'b0; shw_d = 1'b0; ldq_d = 1'b0; shq_d = 1'b0; q0_d = 1'b0;
    d_sel_d = 1'b0; w_sel_d = 1'b0; out_sel_d = 1'b0;
    q_valid_d = 1'b0; r_valid_d = 1'b0; done_d = 1'b0;
    err_dz_d = 1'b0; err_ov_d = 1'b0;
    busy_d = (state_d != IDLE);
    case (state_d)
      LOADX: begin
        ldw_d = 1'b1; w_sel_d = 1'b1; ldq_d = 1'b1;
      end
      SHIFT: begin
        shw_d = 1'b1; shq_d = 1'b1; q0_d = qbit_d;
      end
      SUB: begin
        ldw_d = 1'b1; d_sel_d = 1'b1;
      end
      QFIN: begin
        shq_d = 1'b1; q0_d = qbit_d;
      end
      OUTQ:   q_valid_d = 1'b1;
      OUTR: begin
        out_sel_d = 1'b1; r_valid_d = 1'b1; done_d = 1'b1;
      end
      ERR_DZ: begin
        done_d = 1'b1; err_dz_d = 1'b1;
      end
      ERR_OV: begin
        done_d = 1'b1; err_ov_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      qbit_q    <= 1'b0;
      ldw_q     <= 1'b0;
      shw_q     <= 1'b0;
      ldq_q     <= 1'b0;
      shq_q     <= 1'b0;
      q0_q      <= 1'b0;
      d_sel_q   <= 1'b0;
      w_sel_q   <= 1'b0;
      out_sel_q <= 1'b0;
      busy_q    <= 1'b0;
      q_valid_q <= 1'b0;
      r_valid_q <= 1'b0;
      done_q    <= 1'b0;
      err_dz_q  <= 1'b0;
      err_ov_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      qbit_q    <= qbit_d;
      ldw_q     <= ldw_d;
      shw_q     <= shw_d;
      ldq_q     <= ldq_d;
      shq_q     <= shq_d;
      q0_q      <= q0_d;
      d_sel_q   <= d_sel_d;
      w_sel_q   <= w_sel_d;
      out_sel_q <= out_sel_d;
      busy_q    <= busy_d;
      q_valid_q <= q_valid_d;
      r_valid_q <= r_valid_d;
      done_q    <= done_d;
      err_dz_q  <= err_dz_d;
      err_ov_q  <= err_ov_d;
    end
  end

  // The restore load depends on the subtraction result seen during ADJ, so it cannot be registered.
  assign ldd_o     = (state_q == IDLE) & start_i;
  assign ldw_o     = ldw_q | ((state_q == ADJ) & sign_i);
  assign shw_o     = shw_q;
  assign ldq_o     = ldq_q;
  assign shq_o     = shq_q;
  assign q0_o      = q0_q;
  assign d_sel_o   = d_sel_q;
  assign w_sel_o   = w_sel_q;
  assign out_sel_o = out_sel_q;
  assign busy_o    = busy_q;
  assign q_valid_o = q_valid_q;
  assign r_valid_o = r_valid_q;
  assign done_o    = done_q;
  assign err_dz_o  = err_dz_q;
  assign err_ov_o  = err_ov_q;

endmodule

// File: tb/tb_div_ctrl_fsm.sv
// Testbench for div_ctrl_fsm: a small D/W/Q datapath model closes the loop,
// and directed divisions are checked against hand-computed quotients and timing.
module tb_div_ctrl_fsm;

  logic clk = 1'b0;
  logic rst, start, sign, orD, ovNot;
  logic ldd, ldw, shw, ldq, shq, q0, dSel, wSel, outSel;
  logic busy, qValid, rValid, done, errDz, errOv;

  logic [9:0] dataIn;
  logic [4:0] dReg = '0;
  logic [5:0] wReg = '0;
  logic [4:0] qReg = '0;
  logic [5:0] sum;
  logic [4:0] dataOut;

  int checkCount = 0;
  int passCount  = 0;

  div_ctrl_fsm #(.N(5), .CNT_W(3)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .sign_i(sign), .or_d_i(orD),
    .OV_not_i(ovNot), .ldd_o(ldd), .ldw_o(ldw), .shw_o(shw), .ldq_o(ldq),
    .shq_o(shq), .q0_o(q0), .d_sel_o(dSel), .w_sel_o(wSel), .out_sel_o(outSel),
    .busy_o(busy), .q_valid_o(qValid), .r_valid_o(rValid), .done_o(done),
    .err_dz_o(errDz), .err_ov_o(errOv)
  );

  always #5 clk = ~clk;

  // Datapath model driven by the controller outputs
  assign sum     = dSel ? (wReg - {1'b0, dReg}) : (wReg + {1'b0, dReg});
  assign sign    = wReg[5];
  assign orD     = |dataIn;
  assign ovNot   = (wReg[4:0] < dReg);
  assign dataOut = outSel ? wReg[4:0] : qReg;

  always @(posedge clk) begin
    if (ldd) dReg <= dataIn[4:0];
    if (ldw) wReg <= wSel ? {1'b0, dataIn[9:5]} : sum;
    else if (shw) wReg <= {wReg[4:0], qReg[4]};
    if (ldq) qReg <= dataIn[4:0];
    else if (shq) qReg <= {qReg[3:0], q0};
  end

  // Drives one transaction and records what happens until done or a 40-cycle timeout.
  task automatic run_div(input logic [9:0] dividend, input logic [4:0] divisor, input bit poke,
                         output int qCyc, output int doneCyc, output logic [4:0] qVal,
                         output logic [4:0] rVal, output logic dz, output logic ov,
                         output int qvCount, output int rvCount, output bit sawLdwq,
                         output bit busyGap, output bit lddBusy, output logic lddAtStart);
    qCyc = -1; doneCyc = -1; qVal = 'x; rVal = 'x; dz = 1'b0; ov = 1'b0;
    qvCount = 0; rvCount = 0; sawLdwq = 0; busyGap = 0; lddBusy = 0;
    @(negedge clk);
    start = 1'b1; dataIn = {5'b0, divisor};
    #1 lddAtStart = ldd;
    @(negedge clk);
    start = 1'b0; dataIn = dividend;
    for (int k = 1; k <= 40; k++) begin
      if (qValid) begin qvCount++; qCyc = k; qVal = dataOut; end
      if (rValid) begin rvCount++; rVal = dataOut; end
      if (ldw || ldq) sawLdwq = 1;
      if (!busy) busyGap = 1;
      if (done) begin
        doneCyc = k; dz = errDz; ov = errOv;
        break;
      end
      if (poke && (k == 5 || k == 12)) begin
        start = 1'b1;
        #1 if (ldd) lddBusy = 1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; dataIn = '0;
    repeat (2) @(negedge clk);
    checkCount++;
    if ({ldd, ldw, shw, ldq, shq, q0, dSel, wSel, outSel, busy, qValid, rValid, done, errDz, errOv} !== 15'b0)
      $display("[TB] FAIL reset_outputs: got %b want all zero",
               {ldd, ldw, shw, ldq, shq, q0, dSel, wSel, outSel, busy, qValid, rValid, done, errDz, errOv});
    else passCount++;
    rst = 1'b0;
  endtask

  task automatic test_divide(input string name, input logic [9:0] dividend, input logic [4:0] divisor,
                             input logic [4:0] expQ, input logic [4:0] expR, input bit poke);
    int qCyc, doneCyc, qvCount, rvCount;
    logic [4:0] qVal, rVal;
    logic dz, ov, lddAtStart;
    bit sawLdwq, busyGap, lddBusy;
    run_div(dividend, divisor, poke, qCyc, doneCyc, qVal, rVal, dz, ov, qvCount, rvCount,
            sawLdwq, busyGap, lddBusy, lddAtStart);
    checkCount++;
    if (lddAtStart !== 1'b1) $display("[TB] FAIL %s ldd_at_start: got %b want 1", name, lddAtStart);
    else passCount++;
    checkCount++;
    if (qCyc !== 19) $display("[TB] FAIL %s q_valid_cycle: got %0d want 19", name, qCyc);
    else passCount++;
    checkCount++;
    if (qVal !== expQ) $display("[TB] FAIL %s quotient: got %0d want %0d", name, qVal, expQ);
    else passCount++;
    checkCount++;
    if (doneCyc !== 20) $display("[TB] FAIL %s done_cycle: got %0d want 20", name, doneCyc);
    else passCount++;
    checkCount++;
    if (rVal !== expR) $display("[TB] FAIL %s remainder: got %0d want %0d", name, rVal, expR);
    else passCount++;
    checkCount++;
    if ({dz, ov} !== 2'b00) $display("[TB] FAIL %s errors: got %b want 00", name, {dz, ov});
    else passCount++;
    checkCount++;
    if (qvCount !== 1 || rvCount !== 1)
      $display("[TB] FAIL %s valid_counts: got q%0d r%0d want q1 r1", name, qvCount, rvCount);
    else passCount++;
    checkCount++;
    if (busyGap !== 0) $display("[TB] FAIL %s busy_gap: got %0d want 0", name, busyGap);
    else passCount++;
    if (poke) begin
      checkCount++;
      if (lddBusy !== 0) $display("[TB] FAIL %s ldd_while_busy: got %0d want 0", name, lddBusy);
      else passCount++;
    end
  endtask

  task automatic test_overflow;
    int qCyc, doneCyc, qvCount, rvCount;
    logic [4:0] qVal, rVal;
    logic dz, ov, lddAtStart;
    bit sawLdwq, busyGap, lddBusy;
    run_div(10'd1000, 5'd31, 0, qCyc, doneCyc, qVal, rVal, dz, ov, qvCount, rvCount,
            sawLdwq, busyGap, lddBusy, lddAtStart);
    checkCount++;
    if (doneCyc !== 3) $display("[TB] FAIL ov done_cycle: got %0d want 3", doneCyc);
    else passCount++;
    checkCount++;
    if ({dz, ov} !== 2'b01) $display("[TB] FAIL ov errors: got %b want 01", {dz, ov});
    else passCount++;
    checkCount++;
    if (qvCount !== 0 || rvCount !== 0)
      $display("[TB] FAIL ov valid_counts: got q%0d r%0d want q0 r0", qvCount, rvCount);
    else passCount++;
    @(negedge clk);
    checkCount++;
    if (busy !== 1'b0) $display("[TB] FAIL ov busy_after: got %b want 0", busy);
    else passCount++;
  endtask

  task automatic test_div_zero;
    int qCyc, doneCyc, qvCount, rvCount;
    logic [4:0] qVal, rVal;
    logic dz, ov, lddAtStart;
    bit sawLdwq, busyGap, lddBusy;
    run_div(10'd200, 5'd0, 0, qCyc, doneCyc, qVal, rVal, dz, ov, qvCount, rvCount,
            sawLdwq, busyGap, lddBusy, lddAtStart);
    checkCount++;
    if (doneCyc !== 1) $display("[TB] FAIL dz done_cycle: got %0d want 1", doneCyc);
    else passCount++;
    checkCount++;
    if ({dz, ov} !== 2'b10) $display("[TB] FAIL dz errors: got %b want 10", {dz, ov});
    else passCount++;
    checkCount++;
    if (sawLdwq !== 0) $display("[TB] FAIL dz ldw_ldq_seen: got %0d want 0", sawLdwq);
    else passCount++;
  endtask

  task automatic test_reset_abort;
    bit sawDone = 0;
    @(negedge clk);
    start = 1'b1; dataIn = 10'd7;
    @(negedge clk);
    start = 1'b0; dataIn = 10'd200;
    for (int k = 1; k < 10; k++) begin
      if (done) sawDone = 1;
      @(negedge clk);
    end
    if (done) sawDone = 1;
    rst = 1'b1;
    @(negedge clk);
    checkCount++;
    if ({ldd, ldw, shw, ldq, shq, q0, dSel, wSel, outSel, busy, qValid, rValid, done, errDz, errOv} !== 15'b0)
      $display("[TB] FAIL abort_outputs: got %b want all zero",
               {ldd, ldw, shw, ldq, shq, q0, dSel, wSel, outSel, busy, qValid, rValid, done, errDz, errOv});
    else passCount++;
    checkCount++;
    if (sawDone !== 0) $display("[TB] FAIL abort_no_done: got %0d want 0", sawDone);
    else passCount++;
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_divide("200/7", 10'd200, 5'd7, 5'd28, 5'd4, 0);
    test_divide("991/31", 10'd991, 5'd31, 5'd31, 5'd30, 0);
    test_overflow();
    test_div_zero();
    test_divide("0/1", 10'd0, 5'd1, 5'd0, 5'd0, 0);
    test_divide("b2b_1/1", 10'd1, 5'd1, 5'd1, 5'd0, 0);
    test_reset_abort();
    test_divide("restart_200/7", 10'd200, 5'd7, 5'd28, 5'd4, 1);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
